// File: rtl/canny_pkg.sv
// Shared types and widths for the streaming Canny stages.
package canny_pkg;

  localparam int MAG_W  = 8;
  localparam int GRAD_W = 10;

  typedef enum logic [1:0] {DIR_0, DIR_45, DIR_90, DIR_135} grad_dir_t;

  typedef enum logic [1:0] {ST_PROLOGUE, ST_COMPUTE, ST_WRITE, ST_SHIFT} nms_state_t;

endpackage

// File: rtl/window_shift_reg.sv
// 3x3 raster window: 2*WIDTH+3 entry shift register, entry 0 oldest, new word enters at the top.
// One-cycle update on shift_en_i; clear_i and reset_i zero every entry.
module window_shift_reg #(
  parameter int WIDTH  = 1280,
  parameter int DATA_W = 10
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            clear_i,
  input  logic                            shift_en_i,
  input  logic [DATA_W-1:0]               shift_in_i,
  output logic [(2*WIDTH+3)*DATA_W-1:0]   window_o
);

  localparam int DEPTH = 2*WIDTH + 3;

  logic [DEPTH*DATA_W-1:0] taps_q;

  // Entry i lives at bits [i*DATA_W +: DATA_W]; a right shift moves entry i+1 into i.
  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      taps_q <= '0;
    end else if (shift_en_i) begin
      taps_q <= {shift_in_i, taps_q[DEPTH*DATA_W-1:DATA_W]};
    end
  end

  assign window_o = taps_q;

endmodule

// File: rtl/canny_nms.sv
// Canny non-maximum suppression: 3 cycles/pixel, first write 2 cycles after the (WIDTH+2)-th read.
// Stalls in SHIFT on in_empty and in WRITE on out_full; nothing is dropped or reordered.
module canny_nms
  import canny_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720
) (
  input  logic              clock,
  input  logic              reset,
  output logic              in_rd_en,
  input  logic              in_empty,
  input  logic [GRAD_W-1:0] in_dout,
  output logic              out_wr_en,
  input  logic              out_full,
  output logic [MAG_W-1:0]  out_din
);

  localparam int ROW_W = $clog2(HEIGHT);
  localparam int COL_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH*HEIGHT+1);
  localparam int PRO_W = $clog2(WIDTH+3);

  localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(WIDTH*HEIGHT);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(HEIGHT-1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(WIDTH-1);
  localparam logic [PRO_W-1:0] PRO_LAST  = PRO_W'(WIDTH+1);

  localparam int IDX_NW = 0;
  localparam int IDX_N  = 1;
  localparam int IDX_NE = 2;
  localparam int IDX_W  = WIDTH;
  localparam int IDX_C  = WIDTH + 1;
  localparam int IDX_E  = WIDTH + 2;
  localparam int IDX_SW = 2*WIDTH;
  localparam int IDX_S  = 2*WIDTH + 1;
  localparam int IDX_SE = 2*WIDTH + 2;

  nms_state_t       state_q, state_d;
  logic [CNT_W-1:0] in_count_q, in_count_d;
  logic [PRO_W-1:0] pro_cnt_q, pro_cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [MAG_W-1:0] result_q, result_d;

  logic                            shift_en;
  logic                            win_clear;
  logic [GRAD_W-1:0]               shift_in;
  logic [(2*WIDTH+3)*GRAD_W-1:0]   win_flat;
  logic                            src_data;
  logic                            src_pad;
  logic                            src_avail;

  logic [GRAD_W-1:0] nw_dat, n_dat, ne_dat, w_dat, c_dat, e_dat, sw_dat, s_dat, se_dat;
  logic [GRAD_W-1:0] a_dat, b_dat;
  logic [MAG_W-1:0]  mag_c;
  grad_dir_t         dir_c;
  logic              is_border;
  logic              keep;
  logic              unused_win;

  window_shift_reg #(
    .WIDTH  (WIDTH),
    .DATA_W (GRAD_W)
  ) u_window (
    .clock_i    (clock),
    .reset_i    (reset),
    .clear_i    (win_clear),
    .shift_en_i (shift_en),
    .shift_in_i (shift_in),
    .window_o   (win_flat)
  );

  assign nw_dat = win_flat[IDX_NW*GRAD_W +: GRAD_W];
  assign n_dat  = win_flat[IDX_N *GRAD_W +: GRAD_W];
  assign ne_dat = win_flat[IDX_NE*GRAD_W +: GRAD_W];
  assign w_dat  = win_flat[IDX_W *GRAD_W +: GRAD_W];
  assign c_dat  = win_flat[IDX_C *GRAD_W +: GRAD_W];
  assign e_dat  = win_flat[IDX_E *GRAD_W +: GRAD_W];
  assign sw_dat = win_flat[IDX_SW*GRAD_W +: GRAD_W];
  assign s_dat  = win_flat[IDX_S *GRAD_W +: GRAD_W];
  assign se_dat = win_flat[IDX_SE*GRAD_W +: GRAD_W];
  assign unused_win = ^win_flat;

  assign mag_c = c_dat[MAG_W-1:0];
  assign dir_c = grad_dir_t'(c_dat[GRAD_W-1:MAG_W]);

  // Neighbours lie along the gradient, i.e. across the edge being thinned.
  always_comb begin
    a_dat = w_dat;
    b_dat = e_dat;
    case (dir_c)
      DIR_0:   begin a_dat = w_dat;  b_dat = e_dat;  end
      DIR_45:  begin a_dat = ne_dat; b_dat = sw_dat; end
      DIR_90:  begin a_dat = n_dat;  b_dat = s_dat;  end
      DIR_135: begin a_dat = nw_dat; b_dat = se_dat; end
      default: begin a_dat = w_dat;  b_dat = e_dat;  end
    endcase
  end

  assign keep      = (mag_c >= a_dat[MAG_W-1:0]) && (mag_c >= b_dat[MAG_W-1:0]);
  assign is_border = (row_q == '0) || (row_q == LAST_ROW) || (col_q == '0) || (col_q == LAST_COL);

  // Once the frame is fully read, zeros are shifted in to walk the last row past the centre.
  assign src_data  = (in_count_q < PIX_TOTAL) && !in_empty;
  assign src_pad   = (in_count_q == PIX_TOTAL);
  assign src_avail = src_data || src_pad;
  assign shift_in  = src_data ? in_dout : '0;

  always_comb begin
    state_d    = state_q;
    in_count_d = in_count_q;
    pro_cnt_d  = pro_cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    result_d   = result_q;
    shift_en   = 1'b0;
    win_clear  = 1'b0;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;

    case (state_q)
      ST_PROLOGUE: begin
        if (src_avail) begin
          shift_en  = 1'b1;
          pro_cnt_d = pro_cnt_q + 1'b1;
          if (pro_cnt_q == PRO_LAST) state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        result_d = (keep && !is_border) ? mag_c : '0;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          if (row_q == LAST_ROW && col_q == LAST_COL) begin
            row_d      = '0;
            col_d      = '0;
            in_count_d = '0;
            pro_cnt_d  = '0;
            win_clear  = 1'b1;
            state_d    = ST_PROLOGUE;
          end else begin
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (src_avail) begin
          shift_en = 1'b1;
          state_d  = ST_COMPUTE;
        end
      end
      default: state_d = ST_PROLOGUE;
    endcase

    if (shift_en && src_data) begin
      in_rd_en   = 1'b1;
      in_count_d = in_count_q + 1'b1;
    end

    if (reset) begin
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_PROLOGUE;
      in_count_q <= '0;
      pro_cnt_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_count_q <= in_count_d;
      pro_cnt_q  <= pro_cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      result_q   <= result_d;
    end
  end

  assign out_din = result_q;

endmodule
